cpu_boot_controller: RTL
========================

Name: cpu_boot_controller

Overview:
Sequences one VerySimpleCPU instance and shares its single-port RAM with a host. The host loads a program image into RAM, then starts the CPU for a bounded number of cycles. When the run ends, the CPU is returned to reset and the host can read results back.
The block sits between the CPU, the RAM and the host, and owns the RAM port mux and the CPU reset line.

Parameters:
SIZE, 14, RAM address width (matches CPU addr_toRAM width)
CNT_W, 32, width of run-cycle limit and counter

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
load_start  input  1  pulse: begin program load at address 0
load_valid  input  1  host load word valid
load_data  input  32  host load word
load_last  input  1  marks final load word
load_ready  output  1  controller accepts load word this cycle
run_start  input  1  pulse: release CPU for run_limit cycles
run_limit  input  CNT_W  cycle budget, sampled on run_start
run_abort  input  1  terminate run early
busy  output  1  state != IDLE
done  output  1  sticky: run finished
rd_req  input  1  host RAM read request (IDLE only)
rd_addr  input  SIZE  host read address
rd_ack  output  1  one-cycle pulse, rd_data valid
rd_data  output  32  host read data (registered)
cpu_rst  output  1  registered reset to CPU (synchronous inside CPU)
cpu_wrEn  input  1  CPU write enable
cpu_addr  input  SIZE  CPU RAM address
cpu_wdata  input  32  CPU write data
cpu_rdata  output  32  data to CPU, equals ram_rdata at all times
ram_wrEn  output  1  RAM write enable
ram_addr  output  SIZE  RAM address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, one-cycle synchronous read latency

Behaviour:
- Interface: one clock (clk); rst is asynchronous, active-high.
- Reset values: state=IDLE, cpu_rst=1, done=0, rd_ack=0, rd_data=0, load_addr=0, cycle_cnt=0. busy=0 and load_ready=0 follow from IDLE.
- States: IDLE, LOAD, RUN, READ.
- RAM mux (combinational):
  - RUN: ram_* = cpu_*.
  - LOAD: ram_wrEn=load_valid, ram_addr=load_addr, ram_wdata=load_data.
  - IDLE with rd_req: ram_addr=rd_addr, ram_wrEn=0.
  - Otherwise: all ram_* outputs are 0.
- IDLE start priority: load_start > run_start > rd_req. Only the highest-priority event is taken; the others are dropped.
- load_start: clear done, load_addr=0, go to LOAD.
- LOAD:
  - load_ready=1.
  - Each cycle with load_valid=1: write the word, then load_addr+1.
  - Exit to IDLE after the write where load_last=1 or load_addr==2^SIZE-1, whichever comes first. Writing the top address terminates the load; there is no wrap.
  - load_valid=0 leaves the state unchanged.
  - run_start and rd_req are ignored in LOAD.
- run_start:
  - Clear done, latch run_limit, cycle_cnt=0.
  - If run_limit==0: set done, stay IDLE, cpu_rst stays 1.
  - Else go to RUN; cpu_rst falls on the same edge.
- RUN:
  - cycle_cnt increments every cycle.
  - When cycle_cnt==limit-1, or run_abort=1: next edge sets cpu_rst=1 and done=1, and returns to IDLE.
  - Hence cpu_rst is low for exactly run_limit cycles, or fewer on abort.
  - CPU writes pass to RAM unmodified during every RUN cycle, including the last.
- READ:
  - rd_req sampled in IDLE at cycle T moves to READ.
  - At the end of T+1: rd_data<=ram_rdata, rd_ack<=1, return to IDLE.
  - rd_ack is high during T+2 only. Latency is 2 cycles.
  - rd_req still high at T+2 starts a new read.
- done stays high until the next load_start or run_start.
- Async rst in any state, including mid-LOAD or mid-RUN, returns to reset values immediately. cpu_rst asserts asynchronously. RAM contents are not touched.
- Width rules:
  - load_addr and cycle_cnt wrap is unreachable by construction.
  - Counter comparison is unsigned CNT_W-bit.

Test Plan:
1. Load 3 words {0x9000_4005, 0x0000_0001, 0x1234_5678} with load_last on the 3rd. Expect: RAM[0..2] match, load_ready=1 for 3 cycles, busy falls the cycle after the 3rd write.
2. Load image without load_last and SIZE=4. Expect: load stops after addr 15, and a 17th valid word is not written.
3. Load program "CPi 5 <- 0x2A", then run_limit=10. Expect: cpu_rst low for exactly 10 cycles, done=1, RAM[5]=0x2A; rd_addr=5 gives rd_ack two cycles after rd_req with rd_data=0x2A.
4. run_limit=0. Expect: done=1 the next cycle, cpu_rst never falls, no RAM writes.
5. run_limit=1000, run_abort at cycle 7. Expect: cpu_rst=1 and done=1 at the next edge, cycle_cnt stops, state=IDLE.
6. Assert rst mid-LOAD after 2 words, then load_start and run_start in the same cycle. Expect: cpu_rst=1 immediately; after release, LOAD is taken and run_start is dropped.

Source files
------------

// File: rtl/cpu_boot_controller.sv
// rtl/cpu_boot_controller.sv - Boot sequencer sharing one RAM port between a host loader/reader and a CPU.
// Owns the RAM port mux and the CPU reset line; runs the CPU for a bounded cycle budget.
module cpu_boot_controller #(
  parameter int SIZE  = 14,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start,
  input  logic             load_valid,
  input  logic [31:0]      load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             run_start,
  input  logic [CNT_W-1:0] run_limit,
  input  logic             run_abort,
  output logic             busy,
  output logic             done,
  input  logic             rd_req,
  input  logic [SIZE-1:0]  rd_addr,
  output logic             rd_ack,
  output logic [31:0]      rd_data,
  output logic             cpu_rst,
  input  logic             cpu_wrEn,
  input  logic [SIZE-1:0]  cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             ram_wrEn,
  output logic [SIZE-1:0]  ram_addr,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, READ} state_t;

  localparam logic [SIZE-1:0]  ADDR_TOP = '1;
  localparam logic [SIZE-1:0]  ADDR_ONE = SIZE'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q;
  logic             cpu_rst_q;
  logic             done_q;
  logic             rd_ack_q;
  logic [31:0]      rd_data_q;
  logic [SIZE-1:0]  load_addr_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] limit_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cpu_rst_q   <= 1'b1;
      done_q      <= 1'b0;
      rd_ack_q    <= 1'b0;
      rd_data_q   <= '0;
      load_addr_q <= '0;
      cycle_cnt_q <= '0;
      limit_q     <= '0;
    end else begin
      rd_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_start) begin
            done_q      <= 1'b0;
            load_addr_q <= '0;
            state_q     <= LOAD;
          end else if (run_start) begin
            limit_q     <= run_limit;
            cycle_cnt_q <= '0;
            // A zero budget completes immediately without ever releasing the CPU.
            if (run_limit == '0) begin
              done_q <= 1'b1;
            end else begin
              done_q    <= 1'b0;
              cpu_rst_q <= 1'b0;
              state_q   <= RUN;
            end
          end else if (rd_req) begin
            state_q <= READ;
          end
        end
        LOAD: begin
          if (load_valid) begin
            if (load_last || load_addr_q == ADDR_TOP) state_q <= IDLE;
            if (load_addr_q != ADDR_TOP) load_addr_q <= load_addr_q + ADDR_ONE;
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_q + CNT_ONE;
          if (run_abort || cycle_cnt_q == limit_q - CNT_ONE) begin
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end
        end
        READ: begin
          rd_data_q <= ram_rdata;
          rd_ack_q  <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ram_wrEn  = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (state_q)
      RUN: begin
        ram_wrEn  = cpu_wrEn;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
      end
      LOAD: begin
        ram_wrEn  = load_valid;
        ram_addr  = load_addr_q;
        ram_wdata = load_data;
      end
      IDLE: begin
        // Present the read address early so RAM data is ready during READ.
        if (rd_req && !load_start && !run_start) ram_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign cpu_rdata  = ram_rdata;
  assign cpu_rst    = cpu_rst_q;
  assign done       = done_q;
  assign rd_ack     = rd_ack_q;
  assign rd_data    = rd_data_q;
  assign busy       = (state_q != IDLE);
  assign load_ready = (state_q == LOAD);

endmodule
